// File: rtl/scroll_ctrl.sv
// ---------------------------------------------------------------------------
// scroll_ctrl
// Scroll-address generator for the scrolling-text display path. A
// programmable prescaler produces advance events that step the message
// memory read pointer in wrap, ping-pong or one-shot fashion, forwards or
// backwards, against a runtime message length. The pointer can be paused,
// stepped by hand and restarted.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   i_en         1 = automatic scrolling, 0 = paused (prescaler holds)
//   i_step       manual advance pulse, honoured only while i_en = 0
//   i_restart    synchronous restart, highest priority
//   i_dir        0 = forward, 1 = backward
//   i_mode       00 wrap, 01 ping-pong, 10 one-shot, 11 wrap
//   i_period     cycles between automatic advances minus 1
//   i_msg_last   last valid address (message length - 1)
//   o_addr       registered memory pointer
//   o_tick       1-cycle pulse in the cycle o_addr shows a new value
//   o_wrap       1-cycle pulse on wrap-around / ping-pong reversal
//   o_done       level, one-shot end reached
//   o_dbg_cnt    prescaler count (observability)
//   o_dbg_dir_q  ping-pong travel direction, 1 = backward (observability)
//
// Handshake: o_tick is a valid strobe without backpressure; the consumer
// must take o_addr in the cycle o_tick is high. o_wrap only ever accompanies
// the pointer update it describes.
// ---------------------------------------------------------------------------
module scroll_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DIV_W  = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_step,
    input  logic              i_restart,
    input  logic              i_dir,
    input  logic [1:0]        i_mode,
    input  logic [DIV_W-1:0]  i_period,
    input  logic [ADDR_W-1:0] i_msg_last,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tick,
    output logic              o_wrap,
    output logic              o_done,
    output logic [DIV_W-1:0]  o_dbg_cnt,
    output logic              o_dbg_dir_q
);

    localparam logic [1:0]        MODE_PINGPONG = 2'b01;
    localparam logic [1:0]        MODE_ONESHOT  = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  CNT_ONE       = DIV_W'(1);

    logic [DIV_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_dir_q;
    logic              r_tick;
    logic              r_wrap;
    logic              r_done;

    logic              w_pingpong;
    logic              w_oneshot;
    logic              w_adv;
    logic              w_back;
    logic              w_term;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_next_wrap;
    logic              w_next_done;
    logic              w_next_dir_q;

    assign w_pingpong = (i_mode == MODE_PINGPONG);
    assign w_oneshot  = (i_mode == MODE_ONESHOT);

    // Automatic advance when the prescaler expires; manual step only while paused.
    assign w_adv  = i_en ? (r_cnt == '0) : i_step;
    // Ping-pong follows its own stored direction, other modes follow i_dir.
    assign w_back = w_pingpong ? r_dir_q : i_dir;
    // Terminal address in the current travel direction.
    assign w_term = w_back ? (r_addr == '0) : (r_addr == i_msg_last);

    always_comb begin
        w_next_addr  = r_addr;
        w_next_wrap  = 1'b0;
        // done survives only while the block stays in one-shot mode.
        w_next_done  = w_oneshot & r_done;
        w_next_dir_q = r_dir_q;
        if (w_adv && !(w_oneshot && r_done)) begin
            if (r_addr > i_msg_last) begin
                // Message shortened under the pointer: re-enter at the near end.
                w_next_addr = w_back ? i_msg_last : '0;
                w_next_wrap = 1'b1;
            end else if (w_pingpong) begin
                // A one-character message has nowhere to bounce to.
                if (i_msg_last != '0) begin
                    if (w_term) begin
                        w_next_addr  = w_back ? ADDR_ONE : (i_msg_last - ADDR_ONE);
                        w_next_dir_q = ~w_back;
                        w_next_wrap  = 1'b1;
                    end else begin
                        w_next_addr = w_back ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
                    end
                end
            end else if (w_term) begin
                if (w_oneshot) begin
                    w_next_done = 1'b1;
                end else begin
                    w_next_addr = w_back ? i_msg_last : '0;
                    w_next_wrap = 1'b1;
                end
            end else begin
                w_next_addr = w_back ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '1;
            r_addr  <= '0;
            r_dir_q <= 1'b0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (i_restart) begin
                r_addr  <= (i_dir && !w_pingpong) ? i_msg_last : '0;
                r_dir_q <= i_dir;
                r_cnt   <= i_period;
                r_done  <= 1'b0;
            end else begin
                if (i_en) begin
                    r_cnt <= (r_cnt == '0) ? i_period : (r_cnt - CNT_ONE);
                end
                r_addr  <= w_next_addr;
                r_dir_q <= w_next_dir_q;
                r_done  <= w_next_done;
                r_wrap  <= w_next_wrap;
                // An advance that leaves the pointer in place is not a tick.
                r_tick  <= (w_next_addr != r_addr);
            end
        end
    end

    assign o_addr      = r_addr;
    assign o_tick      = r_tick;
    assign o_wrap      = r_wrap;
    assign o_done      = r_done;
    assign o_dbg_cnt   = r_cnt;
    assign o_dbg_dir_q = r_dir_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scroll_ctrl
// Self-checking bench for scroll_ctrl (ADDR_W=4, DIV_W=4). A behavioural
// model tracks pointer position, prescaler countdown, bounce direction and
// done flag as integers. Every pointer event it predicts (tick, wrap or a
// done change) is queued with its cycle stamp; a negedge monitor pops and
// compares whenever the DUT shows such an event, and also compares the
// pointer level every cycle. Directed scenarios add fixed expected sequences.
// ---------------------------------------------------------------------------
module tb_scroll_ctrl;

    localparam int ADDR_W = 4;
    localparam int DIV_W  = 4;
    localparam int EV_W   = 23;   // {cycle[15:0], addr[3:0], tick, wrap, done}

    logic              clk;
    logic              reset;
    logic              en;
    logic              step;
    logic              restart;
    logic              dir;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  period;
    logic [ADDR_W-1:0] msg_last;
    logic [ADDR_W-1:0] addr;
    logic              tick;
    logic              wrap;
    logic              done;
    logic [DIV_W-1:0]  dbg_cnt;
    logic              dbg_dir_q;

    scroll_ctrl #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (en),
        .i_step     (step),
        .i_restart  (restart),
        .i_dir      (dir),
        .i_mode     (mode),
        .i_period   (period),
        .i_msg_last (msg_last),
        .o_addr     (addr),
        .o_tick     (tick),
        .o_wrap     (wrap),
        .o_done     (done),
        .o_dbg_cnt  (dbg_cnt),
        .o_dbg_dir_q(dbg_dir_q)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EV_W-1:0]   exp_q[$];
    logic [ADDR_W-1:0] tick_log[$];
    bit                wrap_log[$];
    int                tick_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc    = 0;
    int m_pos  = 0;
    int m_cnt  = (1 << DIV_W) - 1;
    bit m_back = 0;
    bit m_done = 0;

    always @(posedge clk or posedge reset) begin
        int  old_pos, last;
        bit  old_done, adv, back, m_tick, m_wrap;
        if (reset) begin
            m_pos  = 0;
            m_cnt  = (1 << DIV_W) - 1;
            m_back = 0;
            m_done = 0;
            exp_q.delete();
        end else begin
            cyc++;
            old_pos  = m_pos;
            old_done = m_done;
            m_wrap   = 0;
            last     = int'(msg_last);
            if (restart) begin
                m_pos  = (dir && mode != 2'd1) ? last : 0;
                m_back = dir;
                m_cnt  = int'(period);
                m_done = 0;
            end else begin
                adv = 0;
                if (en) begin
                    if (m_cnt == 0) begin
                        adv   = 1;
                        m_cnt = int'(period);
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end else begin
                    adv = step;
                end
                if (mode != 2'd2) m_done = 0;
                back = (mode == 2'd1) ? m_back : dir;
                if (adv && !(mode == 2'd2 && m_done)) begin
                    if (m_pos > last) begin
                        m_pos  = back ? last : 0;
                        m_wrap = 1;
                    end else if (mode == 2'd1) begin
                        if (last == 0) begin
                            m_pos = m_pos;
                        end else if (!back && m_pos == last) begin
                            m_pos = last - 1; m_back = 1; m_wrap = 1;
                        end else if (back && m_pos == 0) begin
                            m_pos = 1; m_back = 0; m_wrap = 1;
                        end else begin
                            m_pos = back ? m_pos - 1 : m_pos + 1;
                        end
                    end else if (mode == 2'd2) begin
                        if (m_pos == (back ? 0 : last)) m_done = 1;
                        else m_pos = back ? m_pos - 1 : m_pos + 1;
                    end else begin
                        if (!back && m_pos == last) begin
                            m_pos = 0; m_wrap = 1;
                        end else if (back && m_pos == 0) begin
                            m_pos = last; m_wrap = 1;
                        end else begin
                            m_pos = back ? m_pos - 1 : m_pos + 1;
                        end
                    end
                end
            end
            m_tick = (m_pos != old_pos) && !restart;
            if (m_tick || m_wrap || (m_done != old_done))
                exp_q.push_back({16'(cyc), 4'(m_pos), m_tick, m_wrap, m_done});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit prev_done = 0;

    always @(negedge clk) begin
        logic [EV_W-1:0] got, want;
        if (reset) begin
            prev_done = 0;
        end else begin
            chk("addr_level", 32'(addr), 32'(m_pos));
            chk("done_level", 32'(done), 32'(m_done));
            chk("prescaler", 32'(dbg_cnt), 32'(m_cnt));
            chk("dir_q", 32'(dbg_dir_q), 32'(m_back));
            if (tick || wrap || (done != prev_done)) begin
                got = {16'(cyc), addr, tick, wrap, done};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL event: unexpected {cyc,addr,tick,wrap,done}=%h, none expected", got);
                end else begin
                    want = exp_q.pop_front();
                    chk("event", 32'(got), 32'(want));
                end
            end
            if (tick) begin
                tick_log.push_back(addr);
                wrap_log.push_back(wrap);
                tick_cyc.push_back(cyc);
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tick_log.delete();
        wrap_log.delete();
        tick_cyc.delete();
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        #1;
        restart = 1'b0;
        clear_logs();
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic chk_seq(input string name, input int a0, input int a1, input int a2, input int a3);
        int want[4];
        want = '{a0, a1, a2, a3};
        chk({name, "_count"}, 32'(tick_log.size() >= 4), 32'd1);
        if (tick_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk(name, 32'(tick_log[i]), 32'(want[i]));
    endtask

    // ---------------- stimulus ----------------
    int rel;

    initial begin
        reset = 1'b1; en = 1'b1; step = 1'b0; restart = 1'b0; dir = 1'b0;
        mode = 2'd0; period = 4'd2; msg_last = 4'd3;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr", 32'(addr), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(dbg_cnt), 15);

        // Wrap forward: first advance 16 cycles after enable, then every 3.
        rel = cyc;
        reset = 1'b0;
        run(30);
        chk_seq("wrap_fwd", 1, 2, 3, 0);
        if (tick_cyc.size() >= 2) begin
            chk("first_tick_delay", 32'(tick_cyc[0] - rel), 16);
            chk("tick_spacing", 32'(tick_cyc[1] - tick_cyc[0]), 3);
        end
        if (wrap_log.size() >= 4) begin
            chk("wrap_fwd_nowrap", 32'(wrap_log[2]), 0);
            chk("wrap_fwd_wrap", 32'(wrap_log[3]), 1);
        end

        // Wrap backward from msg_last.
        dir = 1'b1;
        pulse_restart();
        chk("bwd_restart_addr", 32'(addr), 3);
        run(13);
        chk_seq("wrap_bwd", 2, 1, 0, 3);
        if (wrap_log.size() >= 4) begin
            chk("wrap_bwd_nowrap", 32'(wrap_log[0]), 0);
            chk("wrap_bwd_wrap", 32'(wrap_log[3]), 1);
        end

        // Ping-pong.
        dir = 1'b0; mode = 2'd1; msg_last = 4'd2; period = 4'd0;
        pulse_restart();
        run(6);
        chk_seq("pingpong", 1, 2, 1, 0);
        if (wrap_log.size() >= 6) begin
            chk("pp_tail4", 32'(tick_log[4]), 1);
            chk("pp_tail5", 32'(tick_log[5]), 2);
            chk("pp_wrap_top", 32'(wrap_log[2]), 1);
            chk("pp_wrap_bottom", 32'(wrap_log[4]), 1);
            chk("pp_nowrap", 32'(wrap_log[1]), 0);
        end

        // One-shot.
        mode = 2'd2;
        pulse_restart();
        run(6);
        chk("oneshot_ticks", 32'(tick_log.size()), 2);
        chk("oneshot_addr", 32'(addr), 2);
        chk("oneshot_done", 32'(done), 1);
        pulse_restart();
        chk("oneshot_restart_addr", 32'(addr), 0);
        chk("oneshot_restart_done", 32'(done), 0);

        // Pause, manual steps, step ignored while enabled.
        mode = 2'd0; msg_last = 4'd15; period = 4'd5; en = 1'b0;
        pulse_restart();
        run(5);
        chk("pause_addr", 32'(addr), 0);
        chk("pause_cnt", 32'(dbg_cnt), 5);
        chk("pause_ticks", 32'(tick_log.size()), 0);
        repeat (3) step_pulse();
        chk("step_addr", 32'(addr), 3);
        chk("step_ticks", 32'(tick_log.size()), 3);
        clear_logs();
        en = 1'b1; step = 1'b1;
        run(4);
        chk("step_ignored_ticks", 32'(tick_log.size()), 0);
        chk("step_ignored_addr", 32'(addr), 3);
        step = 1'b0; en = 1'b0;

        // Message shortened under the pointer.
        period = 4'd0;
        pulse_restart();
        repeat (7) step_pulse();
        chk("pre_shrink_addr", 32'(addr), 7);
        msg_last = 4'd4;
        clear_logs();
        step_pulse();
        chk("shrink_addr", 32'(addr), 0);
        chk("shrink_ticks", 32'(tick_log.size()), 1);
        if (wrap_log.size() >= 1) chk("shrink_wrap", 32'(wrap_log[0]), 1);

        // Asynchronous reset mid-count.
        step_pulse();
        en = 1'b1; period = 4'd9;
        run(4);
        chk("pre_reset_addr", 32'(addr), 2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_addr", 32'(addr), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_wrap", 32'(wrap), 0);
        chk("async_done", 32'(done), 0);
        chk("async_cnt", 32'(dbg_cnt), 15);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 3) != 0);
            step    = 1'($urandom_range(0, 1));
            restart = ($urandom_range(0, 24) == 0);
            dir     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) msg_last = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) period   = 4'($urandom_range(0, 3));
        end
        en = 1'b0; step = 1'b0; restart = 1'b0;
        run(3);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
